axis_rr_mux: RTL
================

// Module: axis_rr_mux
// PURPOSE
//  Packet-granular round-robin merge of NUM_SLAVE_STREAMS AXIS inputs onto one AXIS output.
//  Sits directly upstream of the tdest switch and feeds its single input.
//  Carries tdest through unchanged, so the downstream switch can route each packet.
//  Never interleaves packets: once a source is granted, it holds the output until its tlast beat is accepted.
// PARAMETERS
//  AXIS_BYTES         1  data width in bytes (tdata = AXIS_BYTES*8 bits)
//  AXIS_TDEST_BITS    4  tdest width
//  NUM_SLAVE_STREAMS  4  number of input streams, >=2; $clog2(NUM_SLAVE_STREAMS) <= AXIS_TDEST_BITS
// PORTS
//  clk            in   1                    clock
//  sresetn        in   1                    reset, asynchronous assert, active-low
//  axis_i_tready  out  N                    per-input ready (N = NUM_SLAVE_STREAMS)
//  axis_i_tvalid  in   N                    per-input valid
//  axis_i_tlast   in   N                    per-input last
//  axis_i_tdest   in   N*AXIS_TDEST_BITS    packed, input i at [i*TD +: TD]
//  axis_i_tdata   in   N*AXIS_BYTES*8       packed, input i at [i*W +: W]
//  axis_o_tready  in   1                    output ready
//  axis_o_tvalid  out  1                    output valid (registered)
//  axis_o_tlast   out  1                    output last
//  axis_o_tdest   out  AXIS_TDEST_BITS      output dest
//  axis_o_tdata   out  AXIS_BYTES*8         output data
// BEHAVIOUR
//  Reset values: state IDLE; rr_ptr = N-1, so input 0 wins first; all axis_i_tready = 0;
//   axis_o_tvalid = 0; axis_o_tlast, tdest, tdata = 0; skid buffer empty.
//  FSM states:
//   IDLE: all axis_i_tready = 0. If any tvalid is high, grant <= the first index with tvalid high,
//    searching from rr_ptr+1 upward mod N; next state LOCKED. No beat is accepted in IDLE.
//   LOCKED: axis_i_tready[grant] = skid-buffer input ready; all other readys are 0.
//    A beat is accepted when tvalid & tready on the granted input.
//    Accepted beat with tlast=1: rr_ptr <= grant, next state IDLE.
//  Inter-packet gap: at least 1 cycle at the input side (the IDLE arbitration cycle).
//  Latency: a beat accepted at cycle t is presented on axis_o_* at t+1.
//  Throughput: 1 beat/cycle within a packet while axis_o_tready stays high.
//  Skid buffer: 2 entries.
//   axis_o_tvalid and the buffer's input ready are both registered.
//   Buffer holds no more than 2 beats; never drops or duplicates a beat.
//  Output stability: while axis_o_tvalid=1 and axis_o_tready=0, all axis_o_* stay stable.
//  Valid drop while LOCKED: granted tvalid may go low mid-packet; the grant is held
//   (no timeout) until tlast is accepted.
//  Simultaneous requests: fairness is strictly round-robin at packet granularity.
//   A source cannot win twice in a row while another source has tvalid high at the arbitration cycle.
//  Reset mid-packet: async clear to the reset values above; buffered beats are discarded.
//   The partial packet is truncated; upstream must also be reset.
// CONFIGURATION
//  AXIS_RR_MUX_TDEST_OVERRIDE_EN
//   Defined: axis_o_tdest = index of the granted source, zero-extended to AXIS_TDEST_BITS;
//    axis_i_tdest is ignored.
//   Undefined: axis_i_tdest[grant] passes through, captured with its beat.
// STRUCTURE
//  Package axis_pkg:
//   typedef enum logic {IDLE, LOCKED} rr_state_t;
//   function next_grant(valid, ptr) implementing the round-robin search.
//  Sub-module axis_skid_buffer: 2-entry register slice, params AXIS_BYTES and AXIS_TDEST_BITS,
//   carries tdata, tdest and tlast. Reusable elsewhere in the codebase.
//  Top level: FSM, grant/rr_ptr registers, input mux.
// TESTING
//  Config for all scenarios: N=4, AXIS_BYTES=1.
//  1. All 4 inputs always valid with 1-beat packets, o_tready=1
//     -> output source order 0,1,2,3,0,1; tdata matches each source's value.
//  2. Input 1 sends 3-beat packet A1,A2,A3; input 2 becomes valid during A2
//     -> output A1,A2,A3 then input 2's packet; no interleave.
//  3. 8-beat packet on input 3, o_tready=1
//     -> 8 consecutive axis_o_tvalid cycles; first beat appears 2 cycles after tvalid rises
//        (arbitration cycle + skid register).
//  4. o_tready held low 5 cycles mid-packet
//     -> at most 2 beats accepted during the stall; axis_o_* stable; sequence intact after release.
//  5. sresetn asserted during beat 2 of a 4-beat packet
//     -> same cycle: axis_o_tvalid=0 and all i_tready=0; after release, first grant goes to input 0.
//  6. Build with AXIS_RR_MUX_TDEST_OVERRIDE_EN; input 2 sends tdest=4'hF
//     -> axis_o_tdest=4'h2. Without the macro -> 4'hF.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and the round-robin search used by the AXIS merge logic.
// Optional build macro consumed by axis_rr_mux: AXIS_RR_MUX_TDEST_OVERRIDE_EN.
package axis_pkg;

   // Arbiter state: IDLE picks the next source, LOCKED streams its packet.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } rr_state_t;

   // Upper bound on the number of streams the search function can scan.
   localparam int unsigned RR_MAX_STREAMS = 32;

   // Returns the first index with valid high, scanning upward from ptr+1
   // and wrapping at num. Returns ptr unchanged when nothing is valid.
   function automatic int unsigned next_grant(
      input logic [RR_MAX_STREAMS-1:0] valid,
      input int unsigned               num,
      input int unsigned               ptr
   );
      int unsigned idx;
      int unsigned result;
      logic        found;
      result = ptr;
      found  = 1'b0;
      for (int unsigned k = 1; k <= RR_MAX_STREAMS; k++) begin
         if (k <= num) begin
            idx = ptr + k;
            if (idx >= num) begin
               idx = idx - num;
            end
            if (!found && valid[idx[4:0]]) begin
               result = idx;
               found  = 1'b1;
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXIS register slice carrying tdata, tdest and tlast.
// Both the upstream ready and the downstream valid come straight from flops,
// so this slice breaks timing paths in both directions.
module axis_skid_buffer #(
   parameter int unsigned AXIS_BYTES      = 1,
   parameter int unsigned AXIS_TDEST_BITS = 4
) (
   input  logic                       clk,
   input  logic                       sresetn,
   input  logic                       s_tvalid_i,
   output logic                       s_tready_o,
   input  logic                       s_tlast_i,
   input  logic [AXIS_TDEST_BITS-1:0] s_tdest_i,
   input  logic [AXIS_BYTES*8-1:0]    s_tdata_i,
   output logic                       m_tvalid_o,
   input  logic                       m_tready_i,
   output logic                       m_tlast_o,
   output logic [AXIS_TDEST_BITS-1:0] m_tdest_o,
   output logic [AXIS_BYTES*8-1:0]    m_tdata_o
);
   localparam int unsigned W  = AXIS_BYTES * 8;
   localparam int unsigned BW = W + AXIS_TDEST_BITS + 1;

   logic [BW-1:0] in_beat;
   logic [BW-1:0] out_q,  out_d;
   logic [BW-1:0] skid_q, skid_d;
   logic          out_valid_q,  out_valid_d;
   logic          skid_valid_q, skid_valid_d;
   logic          ready_q,      ready_d;
   logic          push;
   logic          pop;

   assign in_beat = {s_tdata_i, s_tdest_i, s_tlast_i};
   assign push    = s_tvalid_i & ready_q;
   assign pop     = out_valid_q & m_tready_i;

   // Next-state: the output register refills from the skid entry first (oldest
   // beat), then from the input; the skid entry only catches a beat that arrives
   // while the output is stalled. Ready is dropped once the skid entry is full.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (pop || !out_valid_q) begin
         if (skid_valid_q) begin
            // ready_q was low, so no push can coincide with a full skid entry
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (push) begin
            out_d       = in_beat;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (push) begin
         skid_d       = in_beat;
         skid_valid_d = 1'b1;
      end
      ready_d = ~skid_valid_d;
   end

   // State registers; asynchronous clear discards anything buffered.
   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

   assign s_tready_o                          = ready_q;
   assign m_tvalid_o                          = out_valid_q;
   assign {m_tdata_o, m_tdest_o, m_tlast_o}   = out_q;

endmodule

// File: rtl/axis_rr_mux.sv
// Packet-granular round-robin merge of NUM_SLAVE_STREAMS AXIS inputs onto one
// AXIS output, feeding the downstream tdest switch. A granted source owns the
// output until its tlast beat is accepted, so packets never interleave.
// Build macro AXIS_RR_MUX_TDEST_OVERRIDE_EN: when defined, the output tdest is
// the granted source index instead of the source's own tdest.
module axis_rr_mux
   import axis_pkg::*;
#(
   parameter int unsigned AXIS_BYTES        = 1,
   parameter int unsigned AXIS_TDEST_BITS   = 4,
   parameter int unsigned NUM_SLAVE_STREAMS = 4
) (
   input  logic                                         clk,
   input  logic                                         sresetn,
   output logic [NUM_SLAVE_STREAMS-1:0]                 axis_i_tready,
   input  logic [NUM_SLAVE_STREAMS-1:0]                 axis_i_tvalid,
   input  logic [NUM_SLAVE_STREAMS-1:0]                 axis_i_tlast,
   input  logic [NUM_SLAVE_STREAMS*AXIS_TDEST_BITS-1:0] axis_i_tdest,
   input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0]    axis_i_tdata,
   input  logic                                         axis_o_tready,
   output logic                                         axis_o_tvalid,
   output logic                                         axis_o_tlast,
   output logic [AXIS_TDEST_BITS-1:0]                   axis_o_tdest,
   output logic [AXIS_BYTES*8-1:0]                      axis_o_tdata
);
   localparam int unsigned W  = AXIS_BYTES * 8;
   localparam int unsigned TD = AXIS_TDEST_BITS;
   localparam int unsigned GW = $clog2(NUM_SLAVE_STREAMS);

   rr_state_t        state_q,  state_d;
   logic [GW-1:0]    grant_q,  grant_d;
   logic [GW-1:0]    rr_ptr_q, rr_ptr_d;

   logic             mux_tvalid;
   logic             mux_tlast;
   logic [TD-1:0]    mux_tdest;
   logic [W-1:0]     mux_tdata;
   logic             buf_tvalid;
   logic             buf_tready;
   logic             beat_acc;

   // Select the granted source's beat.
   always_comb begin
      mux_tvalid = axis_i_tvalid[grant_q];
      mux_tlast  = axis_i_tlast[grant_q];
      mux_tdata  = axis_i_tdata[grant_q*W +: W];
   end

`ifdef AXIS_RR_MUX_TDEST_OVERRIDE_EN
   // Downstream routes on the source index; the sources' own tdest is ignored.
   logic unused_tdest;
   assign unused_tdest = ^axis_i_tdest;
   assign mux_tdest    = TD'(grant_q);
`else
   // Pass the granted source's tdest through with its beat.
   assign mux_tdest    = axis_i_tdest[grant_q*TD +: TD];
`endif

   // Only the granted input sees ready, and only while its packet is running.
   assign buf_tvalid = (state_q == LOCKED) && mux_tvalid;
   assign beat_acc   = buf_tvalid && buf_tready;

   generate
      for (genvar gi = 0; gi < NUM_SLAVE_STREAMS; gi++) begin : g_ready
         assign axis_i_tready[gi] = (state_q == LOCKED) && (grant_q == GW'(gi)) && buf_tready;
      end
   endgenerate

   // Arbitration FSM: IDLE spends one cycle choosing a source, LOCKED holds the
   // grant (even across valid gaps) until the tlast beat is accepted.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (|axis_i_tvalid) begin
               grant_d = GW'(next_grant(RR_MAX_STREAMS'(axis_i_tvalid),
                                        NUM_SLAVE_STREAMS, 32'(rr_ptr_q)));
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (beat_acc && mux_tlast) begin
               rr_ptr_d = grant_q;
               state_d  = IDLE;
            end
         end
      endcase
   end

   // Arbiter registers; pointer resets to the last index so input 0 wins first.
   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= GW'(NUM_SLAVE_STREAMS - 1);
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   axis_skid_buffer #(
      .AXIS_BYTES      (AXIS_BYTES),
      .AXIS_TDEST_BITS (AXIS_TDEST_BITS)
   ) u_skid (
      .clk        (clk),
      .sresetn    (sresetn),
      .s_tvalid_i (buf_tvalid),
      .s_tready_o (buf_tready),
      .s_tlast_i  (mux_tlast),
      .s_tdest_i  (mux_tdest),
      .s_tdata_i  (mux_tdata),
      .m_tvalid_o (axis_o_tvalid),
      .m_tready_i (axis_o_tready),
      .m_tlast_o  (axis_o_tlast),
      .m_tdest_o  (axis_o_tdest),
      .m_tdata_o  (axis_o_tdata)
   );

endmodule
